// File: rtl/pixel_stream_demux.sv
// Purpose : route one pixel stream to one of two outputs, one whole frame at a time.
// Latency : 1 cycle from input acceptance to OutNValid.
// Backpres: InReady follows only the routed output's stage; the other output drains independently.
//
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   Select                route for the next frame (1 = Out1, 0 = Out2), sampled at frame start
//   InData/InValid/InLast input beat; InReady back to the source
//   OutN{Data,Valid,Last} registered output beat per output; OutNReady from downstream
//   FrameNCount           completed frames per output (wraps)
//   Busy                  high while a multi-beat frame is in progress
module pixel_stream_demux #(
  parameter int DATA_WIDTH  = 24,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Select,
  input  logic [DATA_WIDTH-1:0]  InData,
  input  logic                   InValid,
  input  logic                   InLast,
  output logic                   InReady,
  output logic [DATA_WIDTH-1:0]  Out1Data,
  output logic                   Out1Valid,
  output logic                   Out1Last,
  input  logic                   Out1Ready,
  output logic [DATA_WIDTH-1:0]  Out2Data,
  output logic                   Out2Valid,
  output logic                   Out2Last,
  input  logic                   Out2Ready,
  output logic [COUNT_WIDTH-1:0] Frame1Count,
  output logic [COUNT_WIDTH-1:0] Frame2Count,
  output logic                   Busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  // One beat as held in an output stage.
  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   route_q, route_nxt;
  logic   route;
  logic   accept;
  logic   load1, load2;
  logic   room1, room2;

  beat_t  stage1_q, stage2_q;
  logic   vld1_q, vld2_q;
  logic [COUNT_WIDTH-1:0] cnt1_q, cnt2_q;

  // Route used this cycle: at a frame boundary Select is taken directly so a
  // new frame can start the cycle after the previous one ended.
  assign route = (state == IDLE) ? Select : route_q;

  // A stage can take a beat if it is empty or is being drained this cycle.
  assign room1   = !vld1_q || Out1Ready;
  assign room2   = !vld2_q || Out2Ready;
  assign InReady = route ? room1 : room2;

  assign accept = InValid && InReady;
  assign load1  = accept &&  route;
  assign load2  = accept && !route;

  // Next-state logic: the route is latched only when a multi-beat frame
  // opens; single-beat frames never leave IDLE.
  always_comb begin
    state_nxt = state;
    route_nxt = route_q;
    case (state)
      IDLE: begin
        if (accept && !InLast) begin
          state_nxt = ACTIVE;
          route_nxt = Select;
        end
      end
      ACTIVE: begin
        if (accept && InLast) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      route_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      route_q <= route_nxt;
    end
  end

  // Output stage 1. A load wins over a drain so a simultaneous drain and
  // load keeps the stage full and sustains one beat per cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld1_q   <= 1'b0;
      stage1_q <= '0;
    end else if (load1) begin
      vld1_q   <= 1'b1;
      stage1_q <= beat_t'{last: InLast, data: InData};
    end else if (vld1_q && Out1Ready) begin
      vld1_q   <= 1'b0;
    end
  end

  // Output stage 2, same behaviour.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld2_q   <= 1'b0;
      stage2_q <= '0;
    end else if (load2) begin
      vld2_q   <= 1'b1;
      stage2_q <= beat_t'{last: InLast, data: InData};
    end else if (vld2_q && Out2Ready) begin
      vld2_q   <= 1'b0;
    end
  end

  // Frame counters advance when a frame's last beat is accepted, not when it
  // leaves the output stage; they wrap freely.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      if (load1 && InLast) begin
        cnt1_q <= cnt1_q + CNT_ONE;
      end
      if (load2 && InLast) begin
        cnt2_q <= cnt2_q + CNT_ONE;
      end
    end
  end

  assign Out1Data    = stage1_q.data;
  assign Out1Last    = stage1_q.last;
  assign Out1Valid   = vld1_q;
  assign Out2Data    = stage2_q.data;
  assign Out2Last    = stage2_q.last;
  assign Out2Valid   = vld2_q;
  assign Frame1Count = cnt1_q;
  assign Frame2Count = cnt2_q;
  assign Busy        = (state == ACTIVE);

endmodule

// File: tb/tb_pixel_stream_demux.sv
// Purpose : scoreboard bench for pixel_stream_demux (COUNT_WIDTH = 2 to reach counter wrap).
// Latency : expects each accepted beat in its output stage one cycle after acceptance.
// Backpres: drives OutNReady low in directed windows to exercise holding and independent drain.
module tb_pixel_stream_demux;

  localparam int DW = 24;
  localparam int CW = 2;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Select;
  logic [DW-1:0] InData;
  logic          InValid;
  logic          InLast;
  logic          InReady;
  logic [DW-1:0] Out1Data, Out2Data;
  logic          Out1Valid, Out2Valid;
  logic          Out1Last, Out2Last;
  logic          Out1Ready, Out2Ready;
  logic [CW-1:0] Frame1Count, Frame2Count;
  logic          Busy;

  pixel_stream_demux #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Select(Select),
    .InData(InData), .InValid(InValid), .InLast(InLast), .InReady(InReady),
    .Out1Data(Out1Data), .Out1Valid(Out1Valid), .Out1Last(Out1Last), .Out1Ready(Out1Ready),
    .Out2Data(Out2Data), .Out2Valid(Out2Valid), .Out2Last(Out2Last), .Out2Ready(Out2Ready),
    .Frame1Count(Frame1Count), .Frame2Count(Frame2Count), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  beat_t q1[$];
  beat_t q2[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_c1 = 0;
  int    exp_c2 = 0;
  logic  exp_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen on the falling edge completes on the next rising edge.
  always @(negedge Clock) begin
    if (!Reset && Out1Valid && Out1Ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL out1_unexpected actual=%h required=none", {Out1Last, Out1Data});
      end else begin
        beat_t e;
        e = q1.pop_front();
        chk("out1_beat", {7'd0, Out1Last, Out1Data}, {7'd0, e});
      end
    end
    if (!Reset && Out2Valid && Out2Ready) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL out2_unexpected actual=%h required=none", {Out2Last, Out2Data});
      end else begin
        beat_t e;
        e = q2.pop_front();
        chk("out2_beat", {7'd0, Out2Last, Out2Data}, {7'd0, e});
      end
    end
  end

  // Present one beat; er is the hand-derived output it must land on (1 = Out1).
  // Entered and left at posedge+1.
  task automatic send(input logic [DW-1:0] d, input logic l, input logic sel, input logic er);
    bit done;
    done    = 1'b0;
    InData  = d;
    InLast  = l;
    Select  = sel;
    InValid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clock);
      if (InReady) done = 1'b1;
      @(posedge Clock);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept data=%h", d);
      #1 InValid = 1'b0;
    end else begin
      if (er) q1.push_back(beat_t'{last: l, data: d});
      else    q2.push_back(beat_t'{last: l, data: d});
      if (l && er)  exp_c1 = (exp_c1 + 1) % 4;
      if (l && !er) exp_c2 = (exp_c2 + 1) % 4;
      exp_busy = !l;
      #1 InValid = 1'b0;
      chk("stage_valid", {31'd0, er ? Out1Valid : Out2Valid}, 32'd1);
      chk("stage_data", {8'd0, er ? Out1Data : Out2Data}, {8'd0, d});
      chk("busy", {31'd0, Busy}, {31'd0, exp_busy});
      chk("cnt1", {30'd0, Frame1Count}, exp_c1);
      chk("cnt2", {30'd0, Frame2Count}, exp_c2);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge Clock);
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q1.size() + q2.size());
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [5];
    seq = '{1, 2, 3, 0, 1};
    Reset = 1'b1; Select = 1'b0; InData = '0; InValid = 1'b0; InLast = 1'b0;
    Out1Ready = 1'b1; Out2Ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_v1", {31'd0, Out1Valid}, 32'd0);
    chk("rst_v2", {31'd0, Out2Valid}, 32'd0);
    chk("rst_d1", {7'd0, Out1Last, Out1Data}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_cnt", {28'd0, Frame1Count, Frame2Count}, 32'd0);
    Reset = 1'b0;

    // 4-beat frame to Out1 at full rate.
    for (int i = 1; i <= 4; i++) send(DW'(i), (i == 4), 1'b1, 1'b1);
    drain();
    chk("t1_out2_idle", {31'd0, Out2Valid}, 32'd0);
    chk("t1_cnt1", {30'd0, Frame1Count}, 32'd1);

    // 3-beat frame to Out2; Select toggled mid-frame is ignored.
    send(24'h000010, 1'b0, 1'b0, 1'b0);
    send(24'h000011, 1'b0, 1'b1, 1'b0);
    send(24'h000012, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t2_cnt2", {30'd0, Frame2Count}, 32'd1);
    chk("t2_cnt1", {30'd0, Frame1Count}, 32'd1);

    // Out1 stalls for 5 cycles holding 0xAABBCC.
    send(24'h111111, 1'b0, 1'b1, 1'b1);
    send(24'hAABBCC, 1'b0, 1'b0, 1'b1);
    Out1Ready = 1'b0;
    InData = 24'h222222; InLast = 1'b0; InValid = 1'b1;
    repeat (5) begin
      @(negedge Clock);
      chk("stall_valid", {31'd0, Out1Valid}, 32'd1);
      chk("stall_data", {8'd0, Out1Data}, 32'h00AABBCC);
      chk("stall_inready", {31'd0, InReady}, 32'd0);
    end
    @(posedge Clock);
    #1 Out1Ready = 1'b1;
    send(24'h222222, 1'b0, 1'b0, 1'b1);
    send(24'h333333, 1'b1, 1'b0, 1'b1);
    drain();

    // Frame A parks its last beat on Out1 while frame B flows through Out2.
    send(24'hA00000, 1'b0, 1'b1, 1'b1);
    send(24'hA00001, 1'b1, 1'b1, 1'b1);
    Out1Ready = 1'b0;
    send(24'hB00000, 1'b0, 1'b0, 1'b0);
    send(24'hB00001, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge Clock);
    #1;
    chk("ab_hold_valid", {31'd0, Out1Valid}, 32'd1);
    chk("ab_hold_beat", {7'd0, Out1Last, Out1Data}, {7'd0, 1'b1, 24'hA00001});
    chk("ab_out2_done", {31'd0, Out2Valid}, 32'd0);
    Out1Ready = 1'b1;
    drain();
    chk("ab_out1_drained", {31'd0, Out1Valid}, 32'd0);

    // Reset in the middle of a 5-beat frame, with beat 2 still held.
    send(24'h500001, 1'b0, 1'b1, 1'b1);
    send(24'h500002, 1'b0, 1'b1, 1'b1);
    Reset = 1'b1; Out1Ready = 1'b0;
    @(posedge Clock);
    #1;
    chk("mrst_v1", {31'd0, Out1Valid}, 32'd0);
    chk("mrst_v2", {31'd0, Out2Valid}, 32'd0);
    chk("mrst_busy", {31'd0, Busy}, 32'd0);
    chk("mrst_cnt", {28'd0, Frame1Count, Frame2Count}, 32'd0);
    q1.delete(); q2.delete();
    exp_c1 = 0; exp_c2 = 0; exp_busy = 1'b0;
    Reset = 1'b0; Out1Ready = 1'b1;
    send(24'h600001, 1'b0, 1'b0, 1'b0);
    send(24'h600002, 1'b1, 1'b1, 1'b0);
    drain();
    chk("mrst_cnt2", {30'd0, Frame2Count}, 32'd1);

    // Five single-beat frames to Out1 wrap the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      send(DW'(24'h700000 + i), 1'b1, 1'b1, 1'b1);
      chk("wrap_cnt1", {30'd0, Frame1Count}, seq[i]);
    end
    drain();
    chk("end_q_empty", q1.size() + q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
